// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit CPU datapath: steps each instruction through
// fetch, decode, execute, memory and writeback and drives the datapath strobes.
module cpu_control_fsm #(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       instr_type,
  input  logic             RI_out,
  input  logic [7:0]       instruction_out,
  output logic             ir_load,
  output logic             pc_en,
  output logic             alu_b_sel,
  output logic             flag_we,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             mem_en,
  output logic             mem_we,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5
  } state_e;

  localparam logic [7:0] OpCmp    = 8'b0000_1011;
  localparam logic [3:0] WaitInit = 4'(MEM_WAIT - 1);

  state_e           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q;
  logic             ri_q, cmp_q, store_q, load_q;
  logic             dec_load, retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      retired_q <= '0;
      ri_q      <= 1'b0;
      cmp_q     <= 1'b0;
      store_q   <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (retire) begin
        retired_q <= retired_q + 1'b1;
      end
      if (dec_load) begin
        ri_q    <= RI_out;
        cmp_q   <= (instruction_out == OpCmp);
        store_q <= (instr_type == 2'b01);
        load_q  <= (instr_type == 2'b10);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    dec_load  = 1'b0;
    retire    = 1'b0;
    ir_load   = 1'b0;
    pc_en     = 1'b0;
    alu_b_sel = 1'b0;
    flag_we   = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        ir_load = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        // X/Z on instr_type falls to the default arm and is treated as illegal.
        case (instr_type)
          2'b00: begin
            dec_load = 1'b1;
            state_d  = StExec;
          end
          2'b01, 2'b10: begin
            dec_load = 1'b1;
            wait_d   = WaitInit;
            state_d  = StMem;
          end
          default: begin
            illegal = 1'b1;
            pc_en   = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StExec: begin
        alu_b_sel = ri_q;
        flag_we   = 1'b1;
        if (cmp_q) begin
          pc_en   = 1'b1;
          retire  = 1'b1;
          state_d = StFetch;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        mem_en = 1'b1;
        mem_we = store_q;
        if (wait_q == '0) begin
          if (store_q) begin
            pc_en   = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      StWb: begin
        reg_we    = 1'b1;
        wb_sel    = load_q;
        alu_b_sel = ri_q;
        pc_en     = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StIdle;
    endcase

    // Stall: freeze everything, but still pull unreachable encodings back to IDLE.
    if (!en) begin
      wait_d    = wait_q;
      dec_load  = 1'b0;
      retire    = 1'b0;
      ir_load   = 1'b0;
      pc_en     = 1'b0;
      alu_b_sel = 1'b0;
      flag_we   = 1'b0;
      reg_we    = 1'b0;
      wb_sel    = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      illegal   = 1'b0;
      if (state_q <= StWb) begin
        state_d = state_q;
      end
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: three instances (MEM_WAIT 1..3, the first with a 4-bit retired
// counter) driven by a vector table, directed sequences and a randomized transaction model.
module tb_cpu_control_fsm;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        en    = 1'b0;
  logic [1:0]  itype [3];
  logic        ri    [3];
  logic [7:0]  op    [3];
  logic [11:0] obs   [3];
  logic [15:0] ret   [3];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Cw = (g == 0) ? 4 : 16;
    logic [2:0]    st;
    logic          irl, pce, abs, fwe, rwe, wbs, men, mwe, ilg;
    logic [Cw-1:0] rc;

    cpu_control_fsm #(
      .MEM_WAIT(g + 1),
      .CNT_W   (Cw)
    ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .en             (en),
      .instr_type     (itype[g]),
      .RI_out         (ri[g]),
      .instruction_out(op[g]),
      .ir_load        (irl),
      .pc_en          (pce),
      .alu_b_sel      (abs),
      .flag_we        (fwe),
      .reg_we         (rwe),
      .wb_sel         (wbs),
      .mem_en         (men),
      .mem_we         (mwe),
      .illegal        (ilg),
      .state          (st),
      .retired        (rc)
    );

    assign obs[g] = {st, irl, pce, abs, fwe, rwe, wbs, men, mwe, ilg};
    assign ret[g] = 16'(rc);
  end

  // Expected output word: {state, ir_load, pc_en, alu_b_sel, flag_we, reg_we, wb_sel,
  // mem_en, mem_we, illegal}.
  function automatic logic [11:0] mk(input int st, input bit ir, input bit pc, input bit ab,
                                     input bit fw, input bit rw, input bit ws, input bit me,
                                     input bit mw, input bit il);
    logic [2:0] s;
    s = 3'(st);
    return {s, ir, pc, ab, fw, rw, ws, me, mw, il};
  endfunction

  task automatic chk(input string nm, input int k, input logic [11:0] ew, input logic [15:0] er);
    checks++;
    if (obs[k] !== ew) begin
      errors++;
      $display("FAIL %s dut%0d outputs: got %h expected %h", nm, k, obs[k], ew);
    end
    checks++;
    if (ret[k] !== er) begin
      errors++;
      $display("FAIL %s dut%0d retired: got %0d expected %0d", nm, k, ret[k], er);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive_all(input logic [1:0] t, input logic r, input logic [7:0] o);
    for (int k = 0; k < 3; k++) begin
      itype[k] = t;
      ri[k]    = r;
      op[k]    = o;
    end
  endtask

  typedef struct {
    logic        e;
    logic [1:0]  t;
    logic        r;
    logic [7:0]  o;
    logic [11:0] w;
    int          rt;
  } vec_t;

  vec_t tbl [22];

  // Transaction-level reference: each instruction expands to its list of per-cycle outputs.
  logic [11:0] seq [3][8];
  int          len [3];
  int          ptr [3];
  int          rm  [3];
  bit          idle[3];
  bit          ilg [3];
  logic [1:0]  ct  [3];
  logic        cr  [3];
  logic [7:0]  co  [3];

  task automatic gen_instr(input int k);
    int         t;
    int         n;
    logic       r;
    logic [7:0] o;
    bit         cmp;
    t   = $urandom_range(0, 3);
    r   = 1'($urandom_range(0, 1));
    o   = ($urandom_range(0, 1) == 1) ? 8'h0B : 8'($urandom);
    cmp = (o == 8'h0B);
    ct[k]  = 2'(t);
    cr[k]  = r;
    co[k]  = o;
    ilg[k] = (t == 3);
    seq[k][0] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    seq[k][1] = mk(2, 0, ilg[k], 0, 0, 0, 0, 0, 0, ilg[k]);
    n = 2;
    if (t == 0) begin
      seq[k][n] = mk(3, 0, cmp, r, 1, 0, 0, 0, 0, 0);
      n++;
      if (!cmp) begin
        seq[k][n] = mk(5, 0, 1, r, 0, 1, 0, 0, 0, 0);
        n++;
      end
    end else if (t != 3) begin
      for (int i = 0; i <= k; i++) begin
        seq[k][n] = mk(4, 0, (t == 1) && (i == k), 0, 0, 0, 0, 1, t == 1, 0);
        n++;
      end
      if (t == 2) begin
        seq[k][n] = mk(5, 0, 1, r, 0, 1, 1, 0, 0, 0);
        n++;
      end
    end
    len[k] = n;
    ptr[k] = 0;
  endtask

  initial begin
    logic [11:0] w;
    logic [15:0] er;
    drive_all(2'b00, 1'b0, 8'h00);

    // Vector table: ADDI, CMP, illegal, stalled ALU op, stalled illegal decode.
    tbl[0]  = '{1'b1, 2'b11, 1'b1, 8'h0B, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0};
    tbl[1]  = '{1'b1, 2'b11, 1'b0, 8'h0B, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0};
    tbl[2]  = '{1'b1, 2'b00, 1'b1, 8'h05, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0};
    tbl[3]  = '{1'b1, 2'b11, 1'b0, 8'h0B, mk(3, 0, 0, 1, 1, 0, 0, 0, 0, 0), 0};
    tbl[4]  = '{1'b1, 2'b10, 1'b0, 8'h00, mk(5, 0, 1, 1, 0, 1, 0, 0, 0, 0), 0};
    tbl[5]  = '{1'b1, 2'b00, 1'b0, 8'h0B, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1};
    tbl[6]  = '{1'b1, 2'b00, 1'b0, 8'h0B, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1};
    tbl[7]  = '{1'b1, 2'b00, 1'b1, 8'h05, mk(3, 0, 1, 0, 1, 0, 0, 0, 0, 0), 1};
    tbl[8]  = '{1'b1, 2'b11, 1'b0, 8'h00, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 2};
    tbl[9]  = '{1'b1, 2'b11, 1'b0, 8'h00, mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 1), 2};
    tbl[10] = '{1'b1, 2'b00, 1'b0, 8'h01, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 2};
    tbl[11] = '{1'b1, 2'b00, 1'b0, 8'h01, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 2};
    tbl[12] = '{1'b0, 2'b11, 1'b1, 8'h0B, mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0), 2};
    tbl[13] = '{1'b0, 2'b11, 1'b1, 8'h0B, mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0), 2};
    tbl[14] = '{1'b0, 2'b11, 1'b1, 8'h0B, mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0), 2};
    tbl[15] = '{1'b1, 2'b00, 1'b1, 8'h0B, mk(3, 0, 0, 0, 1, 0, 0, 0, 0, 0), 2};
    tbl[16] = '{1'b1, 2'b10, 1'b1, 8'h0B, mk(5, 0, 1, 0, 0, 1, 0, 0, 0, 0), 2};
    tbl[17] = '{1'b0, 2'b11, 1'b0, 8'h00, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 3};
    tbl[18] = '{1'b1, 2'b11, 1'b0, 8'h00, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 3};
    tbl[19] = '{1'b0, 2'b11, 1'b0, 8'h00, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 3};
    tbl[20] = '{1'b1, 2'b11, 1'b0, 8'h00, mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 1), 3};
    tbl[21] = '{1'b1, 2'b00, 1'b0, 8'h00, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 3};

    do_reset();
    for (int i = 0; i < 22; i++) begin
      en = tbl[i].e;
      drive_all(tbl[i].t, tbl[i].r, tbl[i].o);
      #1;
      for (int k = 0; k < 3; k++) chk($sformatf("table[%0d]", i), k, tbl[i].w, 16'(tbl[i].rt));
      @(negedge clk);
    end

    // STORE on MEM_WAIT 1 and 3, LOAD on MEM_WAIT 2.
    do_reset();
    en = 1'b1;
    itype[0] = 2'b01; itype[1] = 2'b10; itype[2] = 2'b01;
    for (int k = 0; k < 3; k++) begin ri[k] = 1'b0; op[k] = 8'h00; end
    #1;
    for (int k = 0; k < 3; k++) chk("mem_idle", k, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 16'd0);
    @(negedge clk); #1;
    for (int k = 0; k < 3; k++) chk("mem_fetch", k, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 16'd0);
    @(negedge clk); #1;
    for (int k = 0; k < 3; k++) chk("mem_decode", k, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 16'd0);
    @(negedge clk); #1;
    chk("store1_mem", 0, mk(4, 0, 1, 0, 0, 0, 0, 1, 1, 0), 16'd0);
    chk("load2_mem0", 1, mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 0), 16'd0);
    chk("store3_mem0", 2, mk(4, 0, 0, 0, 0, 0, 0, 1, 1, 0), 16'd0);
    @(negedge clk); #1;
    chk("store1_next", 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 16'd1);
    chk("load2_mem1", 1, mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 0), 16'd0);
    chk("store3_mem1", 2, mk(4, 0, 0, 0, 0, 0, 0, 1, 1, 0), 16'd0);
    @(negedge clk); #1;
    chk("load2_wb", 1, mk(5, 0, 1, 0, 0, 1, 1, 0, 0, 0), 16'd0);
    chk("store3_mem2", 2, mk(4, 0, 1, 0, 0, 0, 0, 1, 1, 0), 16'd0);
    @(negedge clk); #1;
    chk("load2_next", 1, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 16'd1);
    chk("store3_next", 2, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 16'd1);

    // Reset asserted in the middle of a MEM_WAIT=3 STORE.
    do_reset();
    en = 1'b1;
    drive_all(2'b01, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    #1;
    chk("rst_pre", 2, mk(4, 0, 0, 0, 0, 0, 0, 1, 1, 0), 16'd0);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) chk("rst_async", k, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk("rst_release", k, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 16'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) chk("rst_fetch", k, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 16'd0);

    // 16 CMPs: the 4-bit counter on dut0 wraps to 0.
    do_reset();
    en = 1'b1;
    drive_all(2'b00, 1'b0, 8'h0B);
    repeat (46) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk("wrap_pre", k, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 16'd15);
    repeat (3) @(negedge clk);
    #1;
    chk("wrap", 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 16'd0);
    chk("no_wrap", 1, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 16'd16);

    // Randomized instructions and stalls against the transaction model.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle[k] = 1'b1;
      rm[k]   = 0;
      ptr[k]  = 0;
      len[k]  = 0;
    end
    repeat (3000) begin
      en = ($urandom_range(0, 4) != 0);
      for (int k = 0; k < 3; k++) begin
        if (!idle[k] && seq[k][ptr[k]][11:9] == 3'd2) begin
          itype[k] = ct[k];
          ri[k]    = cr[k];
          op[k]    = co[k];
        end else begin
          itype[k] = 2'($urandom);
          ri[k]    = 1'($urandom);
          op[k]    = 8'($urandom);
        end
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        w = idle[k] ? 12'h000 : seq[k][ptr[k]];
        if (!en) w[8:0] = '0;
        er = (k == 0) ? 16'(rm[k] & 15) : 16'(rm[k] & 16'hFFFF);
        chk("random", k, w, er);
        if (en) begin
          if (idle[k]) begin
            idle[k] = 1'b0;
            gen_instr(k);
          end else begin
            ptr[k]++;
            if (ptr[k] == len[k]) begin
              if (!ilg[k]) rm[k]++;
              gen_instr(k);
            end
          end
        end
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
